// File: rtl/traffic_phase_ctrl.sv
// Six-phase two-road traffic light sequencer driving an external 4-bit down counter
// as its phase timer, with emergency all-red override and counter fault detection.
module traffic_phase_ctrl #(
    parameter int T_NSG = 9,
    parameter int T_NSY = 2,
    parameter int T_AR  = 1,
    parameter int T_EWG = 9,
    parameter int T_EWY = 2
) (
    input  logic       CP,
    input  logic       _CLR,
    input  logic       _EMG,
    input  logic [3:0] Q,
    input  logic       _Qcc,
    output logic       _LD,
    output logic       M,
    output logic [3:0] DIN,
    output logic [2:0] NS_RYG,
    output logic [2:0] EW_RYG,
    output logic [2:0] PHASE,
    output logic       FAULT
);

    // Handshake with the counter: _LD low for one CP cycle loads DIN asynchronously;
    // the counter decrements on every CP edge that sees _LD high.
    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_NSG   = 3'd1,
        ST_NSY   = 3'd2,
        ST_AR1   = 3'd3,
        ST_EWG   = 3'd4,
        ST_EWY   = 3'd5,
        ST_AR2   = 3'd6,
        ST_EMG   = 3'd7
    } state_t;

    localparam logic [3:0] D_NSG = 4'(T_NSG);
    localparam logic [3:0] D_NSY = 4'(T_NSY);
    localparam logic [3:0] D_AR  = 4'(T_AR);
    localparam logic [3:0] D_EWG = 4'(T_EWG);
    localparam logic [3:0] D_EWY = 4'(T_EWY);

    state_t     state;
    state_t     state_nxt;
    logic       ld_nxt;
    logic [3:0] din_nxt;
    logic       fault_nxt;
    logic       counting;
    logic       bad;

    function automatic logic [3:0] dur(input state_t s);
        case (s)
            ST_NSG:          return D_NSG;
            ST_NSY:          return D_NSY;
            ST_AR1, ST_AR2:  return D_AR;
            ST_EWG:          return D_EWG;
            ST_EWY:          return D_EWY;
            default:         return 4'd0;
        endcase
    endfunction

    function automatic state_t succ(input state_t s);
        case (s)
            ST_NSG:  return ST_NSY;
            ST_NSY:  return ST_AR1;
            ST_AR1:  return ST_EWG;
            ST_EWG:  return ST_EWY;
            ST_EWY:  return ST_AR2;
            default: return ST_NSG;
        endcase
    endfunction

    // {ns, ew} lamp patterns, each {red, yellow, green}
    function automatic logic [5:0] lamps(input state_t s);
        case (s)
            ST_NSG:  return {3'b001, 3'b100};
            ST_NSY:  return {3'b010, 3'b100};
            ST_EWG:  return {3'b100, 3'b001};
            ST_EWY:  return {3'b100, 3'b010};
            default: return {3'b100, 3'b100};
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        ld_nxt    = 1'b1;
        din_nxt   = DIN;
        fault_nxt = FAULT;
        counting  = (state != ST_START) && (state != ST_EMG) && _LD;
        bad       = counting && ((Q > dur(state)) || !_Qcc);
        if (bad) fault_nxt = 1'b1;

        if (!_EMG) begin
            // Holding _LD low keeps the counter frozen at T_AR for the whole override.
            state_nxt = ST_EMG;
            ld_nxt    = 1'b0;
            din_nxt   = D_AR;
        end else if (state == ST_EMG || (counting && bad)) begin
            state_nxt = ST_AR2;
            ld_nxt    = 1'b0;
            din_nxt   = D_AR;
        end else if (state == ST_START) begin
            state_nxt = ST_NSG;
            ld_nxt    = 1'b0;
            din_nxt   = D_NSG;
        end else if (counting && Q == 4'd0) begin
            state_nxt = succ(state);
            ld_nxt    = 1'b0;
            din_nxt   = dur(succ(state));
        end
    end

    always_ff @(posedge CP or negedge _CLR) begin
        if (!_CLR) begin
            state  <= ST_START;
            _LD    <= 1'b1;
            DIN    <= 4'd0;
            FAULT  <= 1'b0;
            NS_RYG <= 3'b100;
            EW_RYG <= 3'b100;
        end else begin
            state            <= state_nxt;
            _LD              <= ld_nxt;
            DIN              <= din_nxt;
            FAULT            <= fault_nxt;
            {NS_RYG, EW_RYG} <= lamps(state_nxt);
        end
    end

    assign PHASE = state;
    assign M     = 1'b0;

endmodule
